// File: rtl/param_regfile.sv
// Parameterised multi-port register file that zeroes itself after every reset
// or clr request, reporting completion of that clear sequence on 'ready'.
module param_regfile #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_b,
  input  logic                   clr,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic                   ready
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             ready_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wrRun;
  logic             memWe;
  logic [AW-1:0]    memAddr;
  logic [WIDTH-1:0] memData;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (clr) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
            if (cnt_q == LAST) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (clr) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // A user write lands only in RUN, never alongside clr, and never into a hard-wired zero register.
  always_comb begin
    wrRun   = (state_q == RUN) && we && !clr && !((ZERO_REG != 0) && (wa == '0));
    memWe   = reset_b && ((state_q == INIT) || wrRun);
    memAddr = (state_q == INIT) ? cnt_q : wa;
    memData = (state_q == INIT) ? '0 : wd;
  end

  always_ff @(posedge clock) begin
    if (memWe) begin
      mem_q[memAddr] <= memData;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_read
    logic [AW-1:0]    raI;
    logic [WIDTH-1:0] rdI;

    assign raI = ra[i*AW +: AW];

    always_comb begin
      rdI = mem_q[raI];
      if ((BYPASS != 0) && wrRun && (wa == raI)) begin
        rdI = wd;
      end
      if ((state_q == INIT) || ((ZERO_REG != 0) && (raI == '0))) begin
        rdI = '0;
      end
    end

    assign rd[i*WIDTH +: WIDTH] = rdI;
  end

  assign ready = ready_q;

endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, 32, data width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, 32, number of registers (power of 2, 2..256); AW = log2(DEPTH).
REQ-003 The block SHALL have parameter NREAD, 2, number of independent read ports (1..4).
REQ-004 The block SHALL have parameter BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = none.
REQ-005 The block SHALL have parameter ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: clock input 1, rising-edge clock.
REQ-007 The block SHALL have port reset_b input 1, asynchronous active-low reset.
REQ-008 The block SHALL have port clr input 1, synchronous request to restart the clear sequence.
REQ-009 The block SHALL have port we input 1, write enable.
REQ-010 The block SHALL have port wa input AW, write address.
REQ-011 The block SHALL have port wd input WIDTH, write data.
REQ-012 The block SHALL have port ra input NREAD*AW, read addresses; port i at bits [i*AW +: AW].
REQ-013 The block SHALL have port rd output NREAD*WIDTH, read data; port i at bits [i*WIDTH +: WIDTH].
REQ-014 The block SHALL have port ready output 1, high when the clear sequence is done and writes are accepted.

Function
REQ-015 FSM states SHALL be INIT and RUN; reset_b low forces INIT with clear counter cnt = 0.
REQ-016 In INIT, each rising clock edge SHALL write 0 to register cnt and increment cnt; the edge with cnt = DEPTH-1 SHALL move the FSM to RUN.
REQ-017 A full clear SHALL take exactly DEPTH clock edges after reset_b deasserts; ready SHALL rise after edge DEPTH.
REQ-018 ready SHALL be registered, 0 in INIT and 1 in RUN.
REQ-019 In INIT, we SHALL be ignored and every rd port SHALL read 0.
REQ-020 In RUN, clr = 1 at an edge SHALL move the FSM to INIT with cnt = 0 and ready = 0, and any we at that edge SHALL be dropped.
REQ-021 In INIT, clr = 1 SHALL reset cnt to 0.
REQ-022 In RUN, we = 1 SHALL write wd to register wa at the rising edge, unless ZERO_REG = 1 and wa = 0.
REQ-023 Reads SHALL be combinational: rd port i = register ra_i, with no clock latency.
REQ-024 With ZERO_REG = 1, ra_i = 0 SHALL always read 0.
REQ-025 With BYPASS = 1 in RUN, when we = 1, wa = ra_i and the write is not suppressed, rd port i SHALL equal wd in the same cycle.
REQ-026 With BYPASS = 0, the new value SHALL become visible only after the write edge.
REQ-027 All NREAD ports SHALL be independent, and identical addresses on several ports SHALL return identical data.
REQ-028 Register contents SHALL be undefined until the first clear completes; the clear sequence is the only supported initialisation.

Reset
REQ-029 Asserting reset_b low at any time, including mid-clear or during a write cycle, SHALL immediately force INIT, cnt = 0 and ready = 0, and SHALL drop any pending write.
REQ-030 rd SHALL read all-zero while reset_b is low.
REQ-031 Deasserting reset_b SHALL start the clear sequence at the next rising edge.

Verification
REQ-032 Reset clear: release reset_b, hold we = 1, wa = 5, wd = 0xDEADBEEF -> ready = 0 for 32 edges and rises after edge 32; then reading ra0 = 5 returns 0.
REQ-033 Write/read: in RUN, write reg 30 = 0x92CC13C7 and reg 1 = 0x2B971485; set ra0 = 30, ra1 = 1 -> rd0 = 0x92CC13C7, rd1 = 0x2B971485.
REQ-034 Zero register: write reg 0 = 0x7EE7081D -> rd reads 0 on both ports; with ZERO_REG = 0 the same write reads back 0x7EE7081D.
REQ-035 Bypass: with BYPASS = 1, set we = 1, wa = 7, wd = 0xFBD6F479 and ra0 = 7 -> rd0 = 0xFBD6F479 before the edge; with BYPASS = 0, rd0 holds the old value until after the edge.
REQ-036 clr mid-run: assert clr with we = 1, wa = 3 -> ready = 0 for 32 edges, the write to reg 3 is dropped, and afterwards every register reads 0.
REQ-037 Reset mid-clear: pulse reset_b low at clear edge 10 -> cnt restarts from 0 and ready rises exactly 32 edges after the release.
